wb_bus_arbiter: RTL

Two-master, one-slave Wishbone classic arbiter that shares a single external memory bus between the CPU's data port (master 0) and instruction port (master 1). It sits between the CPU top-level Wishbone outputs and the system bus. It grants whole bus cycles (held for the full `cyc` window) using round-robin order. A watchdog aborts slave transactions that never acknowledge and returns an error to the owning master.

---
 rtl/wb_bus_arbiter_pkg.sv | 21 ++
 rtl/wb_bus_arbiter_timer.sv | 32 +++
 rtl/wb_bus_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/wb_bus_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  // Arbiter states: idle, bus owned by master 0/1, one-cycle watchdog abort
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  // One-hot grant encodings presented on gnt_o
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Default watchdog limit and counter width
  localparam int TIMEOUT_DEF = 255;
  localparam int TO_W_DEF    = 8;

endpackage

// File: rtl/wb_bus_arbiter_timer.sv
// Watchdog counter: counts stalled strobe cycles and flags the cycle in
// which the count would reach TIMEOUT. A clear in that same cycle (e.g.
// the slave acks) suppresses the expiry.
module wb_arb_timer
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  logic [TO_W-1:0] r_count;

  // Stall counter: clear has priority over increment
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_inc && !i_clear && (r_count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter with round-robin grant of
// whole cyc windows and a watchdog that aborts slaves that never ack.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  // master 0 (data port)
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_data_i,
  input  logic                m0_we_i,
  input  logic                m0_stb_i,
  input  logic                m0_cyc_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  output logic [DATA_W-1:0]   m0_data_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  // master 1 (instruction port)
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_data_i,
  input  logic                m1_we_i,
  input  logic                m1_stb_i,
  input  logic                m1_cyc_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  output logic [DATA_W-1:0]   m1_data_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  // slave side
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_data_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic                s_stb_o,
  output logic                s_cyc_o,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_ack_i,
  // debug grant
  output logic [1:0]          gnt_o
);

  arb_state_t r_state;
  logic       r_last;   // most recently granted (or aborted) master
  logic [1:0] r_gnt;

  logic w_owner_drop;
  logic w_ack_in;
  logic w_clear;
  logic w_expired;

  // Owner releasing the bus this cycle means a fresh grant follows
  assign w_owner_drop = ((r_state == GNT0) && !m0_cyc_i) ||
                        ((r_state == GNT1) && !m1_cyc_i);
  assign w_ack_in     = s_ack_i && ((r_state == GNT0) || (r_state == GNT1));
  assign w_clear      = !s_stb_o || w_ack_in || w_owner_drop;

  wb_arb_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_inc     (s_stb_o),
    .o_expired (w_expired)
  );

  // Arbitration FSM with registered grant and round-robin history bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_gnt   <= GNT_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
            r_state <= GNT0;
            r_gnt   <= GNT_M0;
          end else if (m1_cyc_i) begin
            r_state <= GNT1;
            r_gnt   <= GNT_M1;
          end
        end
        GNT0: begin
          if (!m0_cyc_i) begin
            r_last <= 1'b0;
            if (m1_cyc_i) begin
              r_state <= GNT1;
              r_gnt   <= GNT_M1;
            end else begin
              r_state <= IDLE;
              r_gnt   <= GNT_NONE;
            end
          end else if (w_expired) begin
            r_state <= ABORT;
            r_last  <= 1'b0;
            r_gnt   <= GNT_NONE;
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            r_last <= 1'b1;
            if (m0_cyc_i) begin
              r_state <= GNT0;
              r_gnt   <= GNT_M0;
            end else begin
              r_state <= IDLE;
              r_gnt   <= GNT_NONE;
            end
          end else if (w_expired) begin
            r_state <= ABORT;
            r_last  <= 1'b1;
            r_gnt   <= GNT_NONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= GNT_NONE;
        end
      endcase
    end
  end

  assign gnt_o = r_gnt;

  // Bus mux: slave sees the owner, only the owner sees ack/data; err in ABORT
  always_comb begin
    s_addr_o  = '0;
    s_data_o  = '0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_stb_o   = 1'b0;
    s_cyc_o   = 1'b0;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    case (r_state)
      GNT0: begin
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        s_we_o    = m0_we_i;
        s_sel_o   = m0_sel_i;
        s_stb_o   = m0_stb_i;
        s_cyc_o   = m0_cyc_i;
        m0_data_o = s_data_i;
        m0_ack_o  = s_ack_i;
      end
      GNT1: begin
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        s_we_o    = m1_we_i;
        s_sel_o   = m1_sel_i;
        s_stb_o   = m1_stb_i;
        s_cyc_o   = m1_cyc_i;
        m1_data_o = s_data_i;
        m1_ack_o  = s_ack_i;
      end
      ABORT: begin
        m0_err_o = !r_last;
        m1_err_o = r_last;
      end
      default: begin
      end
    endcase
  end

endmodule
